seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Time-multiplexed 8-digit seven-segment scan driver that produces the CPU top's `enable`, `which` and `code` outputs. Sits downstream of the CPU datapath's display register: it accepts a 32-bit value through a load strobe, double-buffers it, and cycles through the eight hex digits at a programmable rate. New values take effect only at frame boundaries, so digits from two different values never appear in the same scan frame.

## Interface
- `DIV`, 4, clk cycles each digit is held (≥2; 4 for simulation, ~100000 on board).
- `clk  in  1  system clock`
- `rst  in  1  reset, synchronous, active-high`
- `load  in  1  one-cycle strobe; capture data_in`
- `data_in  in  32  value to display; nibble k drives digit k`
- `blank_lz  in  1  1 = blank leading-zero digits`
- `enable  out  1  high when which/code are valid for the panel`
- `which  out  3  currently driven digit index, 0 = least significant nibble`
- `code  out  8  segment pattern, active-low; bit7 = dp, bits6:0 = g..a`
- `frame_done  out  1  one-cycle pulse when the scan wraps from digit 7 to 0`

## Operation
- Registers: `active[31:0]`, `pending[31:0]`, `pend_v`, prescaler `cnt` (clog2(DIV) bits), `which`, state.
- FSM IDLE → SCAN. IDLE exits only on `load`. SCAN never returns to IDLE except on `rst`.
- IDLE + `load`: `active <= data_in`; go to SCAN; `which = 0`, `cnt = 0`.
- SCAN + `load` not at a boundary: `pending <= data_in`, `pend_v <= 1`. With several loads per frame, the last one wins.
- Digit advance: when `cnt == DIV-1`, `cnt <= 0` and `which <= which+1`, wrapping from 7 to 0. Otherwise `cnt` increments.
- Frame boundary is the advance cycle with `which == 7`. It asserts `frame_done` on the next cycle. If `pend_v` is set: `active <= pending`, `pend_v <= 0`.
- `load` on the boundary cycle sends `data_in` straight to `active` and clears `pend_v`. It overrides any older pending value.
- Decode: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, B 83, C C6, D A1, E 86, F 8E.
- Blanking with `blank_lz = 1`: digit k shows `FF` if every nibble ≥ k is zero. Digit 0 is never blanked, so a value of 0 shows "0".
- `blank_lz` is sampled combinationally into the registered `code` each cycle.
- `dp` is always off (bit7 = 1).

## Timing
- Reset values: `enable = 0`, `which = 0`, `code = 8'hFF`, `frame_done = 0`, `active = 0`, `pend_v = 0`, state IDLE, `cnt = 0`.
- All outputs are registered. `code` always matches the `which` shown in the same cycle.
- First `load` in IDLE at cycle N. At N+1: `enable = 1`, `which = 0`, `code = seg(data_in[3:0])`.
- Each digit is held exactly DIV cycles. One frame is 8·DIV cycles.
- A SCAN-time load appears at the first digit 0 after the next boundary. Worst-case latency is 8·DIV cycles.
- `rst` mid-frame: on the next edge, all registers return to their reset values. Pending data is discarded and the block waits in IDLE for a new `load`.
- `frame_done` is high for exactly 1 cycle per frame, coincident with `which` returning to 0.

## Structure
- Package `seg_pkg`:
  - `NUM_DIGITS = 8`
  - `SEG_BLANK = 8'hFF`
  - state enum {IDLE, SCAN}
  - function `hex_seg(nibble)` returning the table above.
- Sub-module `hex_to_seg`: combinational nibble → 8-bit pattern using `seg_pkg`. It is instantiated once on the muxed nibble.
- Leading-zero mask logic stays in the top.

## Test plan
- Reset, then no load for 20 cycles → `enable = 0`, `code = FF`, `which = 0` throughout.
- DIV = 4, load 0x1234ABCD → `which` 0..7 each held 4 cycles. `code` sequence: A1, C6, 83, 88, 99, B0, A4, F9. `frame_done` pulses every 32 cycles.
- Load 0x00000050 with `blank_lz = 1` → codes C0, 92, then FF for digits 2–7. With `blank_lz = 0`, digits 2–7 show C0. Load 0 with `blank_lz = 1` → digit 0 shows C0, the rest FF.
- During a frame showing 0x11111111 (all F9), load 0x22222222 while `which = 3` → the remaining digits stay F9. After the boundary, all digits show A4.
- Loads 0x33333333 and then 0x44444444 in the same frame → the next frame shows 99 on all digits. Separately, a load exactly on the boundary cycle is visible at the immediately following digit 0.
- Assert `rst` for 1 cycle with `which = 5` → the next cycle shows `enable = 0`, `code = FF`, `which = 0`. The block stays blank until a new `load`, then its digit 0 appears 1 cycle later.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared constants, FSM state type and hex-to-segment table for the scan driver.
package seg_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Active-low segment pattern for one hex digit; bit7 (dp) is always off.
    function automatic logic [7:0] hex_seg(input logic [3:0] nibble);
        logic [7:0] seg;
        case (nibble)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bundle between the display-register side and the panel side of the scan driver.
interface seg_scan_driver_if;

    logic        load;
    logic [31:0] data_in;
    logic        blank_lz;
    logic        enable;
    logic [2:0]  which;
    logic [7:0]  code;
    logic        frame_done;

    modport master (
        output load, data_in, blank_lz,
        input  enable, which, code, frame_done
    );

    modport slave (
        input  load, data_in, blank_lz,
        output enable, which, code, frame_done
    );

endinterface

// File: rtl/seg_scan_driver_hex_to_seg.sv
// Combinational nibble to seven-segment decoder.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    assign o_seg = hex_seg(i_nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner with frame-aligned double buffering.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_driver_if.slave   bus
);

    localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [31:0]           r_active;
    logic [31:0]           w_active_next;
    logic [31:0]           r_pending;
    logic [31:0]           w_pending_next;
    logic                  r_pend_v;
    logic                  w_pend_v_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [2:0]            r_which;
    logic [2:0]            w_which_next;
    logic                  r_enable;
    logic [7:0]            r_code;
    logic [7:0]            w_code_next;
    logic                  r_frame_done;

    logic                  w_advance;
    logic                  w_boundary;
    logic [3:0]            w_nibble;
    logic [7:0]            w_seg;
    logic [NUM_DIGITS-1:0] w_upper_zero;

    assign w_advance  = (r_state == SCAN) && (r_cnt == CNT_LAST);
    assign w_boundary = w_advance && (r_which == 3'(NUM_DIGITS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: leave IDLE on the first load, then scan until reset.
    always_comb begin
        w_state_next = r_state;
        if (r_state == IDLE && bus.load) begin
            w_state_next = SCAN;
        end
    end

    // Next-cycle datapath: prescaler, digit index, and active/pending buffer swap.
    always_comb begin
        w_active_next  = r_active;
        w_pending_next = r_pending;
        w_pend_v_next  = r_pend_v;
        w_cnt_next     = r_cnt;
        w_which_next   = r_which;
        if (r_state == IDLE) begin
            if (bus.load) begin
                w_active_next = bus.data_in;
                w_pend_v_next = 1'b0;
                w_cnt_next    = '0;
                w_which_next  = '0;
            end
        end else begin
            if (w_advance) begin
                w_cnt_next   = '0;
                w_which_next = r_which + 3'd1;
            end else begin
                w_cnt_next   = r_cnt + CNT_W'(1);
            end
            // A load on the boundary itself is newer than anything pending.
            if (w_boundary) begin
                if (bus.load) begin
                    w_active_next = bus.data_in;
                    w_pend_v_next = 1'b0;
                end else if (r_pend_v) begin
                    w_active_next = r_pending;
                    w_pend_v_next = 1'b0;
                end
            end else if (bus.load) begin
                w_pending_next = bus.data_in;
                w_pend_v_next  = 1'b1;
            end
        end
    end

    // Decode from next-cycle values so the registered code lines up with which.
    assign w_nibble = w_active_next[{w_which_next, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    // Digit 0 always shows, so a zero value still displays "0".
    assign w_upper_zero[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
            assign w_upper_zero[gi] = ~|w_active_next[31:4*gi];
        end
    endgenerate

    // Output decode: blank while idle or when the digit is a leading zero.
    always_comb begin
        w_code_next = w_seg;
        if (w_state_next != SCAN) begin
            w_code_next = SEG_BLANK;
        end else if (bus.blank_lz && w_upper_zero[w_which_next]) begin
            w_code_next = SEG_BLANK;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active     <= '0;
            r_pending    <= '0;
            r_pend_v     <= 1'b0;
            r_cnt        <= '0;
            r_which      <= '0;
            r_enable     <= 1'b0;
            r_code       <= SEG_BLANK;
            r_frame_done <= 1'b0;
        end else begin
            r_active     <= w_active_next;
            r_pending    <= w_pending_next;
            r_pend_v     <= w_pend_v_next;
            r_cnt        <= w_cnt_next;
            r_which      <= w_which_next;
            r_enable     <= (w_state_next == SCAN);
            r_code       <= w_code_next;
            r_frame_done <= w_boundary;
        end
    end

    assign bus.enable     = r_enable;
    assign bus.which      = r_which;
    assign bus.code       = r_code;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed tables, frame sequences and a random run.
module tb_seg_scan_driver;

    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scan_driver_if bus ();

    seg_scan_driver #(.DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int tcur     = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: time since the first load, the value shown this frame,
    // and the newest load waiting for the next frame.
    bit          m_started = 1'b0;
    int          m_t       = 0;
    logic [31:0] m_val     = '0;
    logic [31:0] m_pend    = '0;
    bit          m_pend_v  = 1'b0;
    bit          m_blz     = 1'b0;

    function automatic void model_update(input logic r, input logic l, input logic [31:0] d, input logic b);
        m_blz = b;
        if (r) begin
            m_started = 1'b0;
            m_t       = 0;
            m_val     = '0;
            m_pend_v  = 1'b0;
        end else if (!m_started) begin
            if (l) begin
                m_started = 1'b1;
                m_t       = 0;
                m_val     = d;
                m_pend_v  = 1'b0;
            end
        end else begin
            if (m_t % FRAME == FRAME - 1) begin
                if (l) begin
                    m_val    = d;
                    m_pend_v = 1'b0;
                end else if (m_pend_v) begin
                    m_val    = m_pend;
                    m_pend_v = 1'b0;
                end
            end else if (l) begin
                m_pend   = d;
                m_pend_v = 1'b1;
            end
            m_t = m_t + 1;
        end
    endfunction

    function automatic int model_which();
        return m_started ? (m_t / DIV) % 8 : 0;
    endfunction

    function automatic logic [7:0] model_code();
        int          dg;
        logic [31:0] upper;
        if (!m_started) return 8'hFF;
        dg    = model_which();
        upper = m_val >> (4 * dg);
        if (m_blz && dg != 0 && upper == 0) return 8'hFF;
        return seg_tab[upper[3:0]];
    endfunction

    function automatic logic model_fd();
        return m_started && m_t > 0 && (m_t % FRAME == 0);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual %0h required %0h", nm, $time, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, settle.
    task automatic step(input logic r, input logic l, input logic [31:0] d, input logic b);
        rst          = r;
        bus.load     = l;
        bus.data_in  = d;
        bus.blank_lz = b;
        @(posedge clk);
        model_update(r, l, d, b);
        #1;
    endtask

    // Run n scanning cycles expecting the digit codes in 'codes' (digit k at [8k+:8]);
    // optionally load 'ld' on step index load_at.
    task automatic scan_steps(input int n, input logic [63:0] codes, input logic b,
                              input int load_at, input logic [31:0] ld);
        for (int k = 0; k < n; k++) begin
            int dg;
            step(1'b0, k == load_at, (k == load_at) ? ld : $urandom, b);
            tcur++;
            dg = (tcur / DIV) % 8;
            $display("scan t=%0d which=%0d code=%h fd=%b", tcur, bus.which, bus.code, bus.frame_done);
            check("scan_enable", bus.enable, 1);
            check("scan_which", bus.which, dg);
            check("scan_code", bus.code, codes[8*dg +: 8]);
            check("scan_frame_done", bus.frame_done, (tcur % FRAME) == 0);
        end
    endtask

    typedef struct {
        logic        ld;
        logic [31:0] data;
        logic        blz;
        logic        exp_en;
        logic [2:0]  exp_which;
        logic [7:0]  exp_code;
        logic        exp_fd;
    } vec_t;

    localparam int NV = 20 + 2 * FRAME + 1;
    vec_t vecs [NV];

    logic [63:0] c_abcd, all_f9, all_a4, all_99, all_88, blank50, plain50, zero_blz;

    initial begin
        c_abcd   = 64'hF9A4B0998883C6A1;
        all_f9   = 64'hF9F9F9F9F9F9F9F9;
        all_a4   = 64'hA4A4A4A4A4A4A4A4;
        all_99   = 64'h9999999999999999;
        all_88   = 64'h8888888888888888;
        blank50  = 64'hFFFFFFFFFFFF92C0;
        plain50  = 64'hC0C0C0C0C0C092C0;
        zero_blz = 64'hFFFFFFFFFFFFFFC0;

        // Table: 20 idle cycles with ignored data, then load 0x1234ABCD and scan two frames.
        for (int i = 0; i < NV; i++) begin
            if (i < 20) begin
                vecs[i] = '{ld: 1'b0, data: $urandom, blz: 1'b0, exp_en: 1'b0,
                            exp_which: 3'd0, exp_code: 8'hFF, exp_fd: 1'b0};
            end else begin
                int t, dg;
                t  = i - 20;
                dg = (t / DIV) % 8;
                vecs[i] = '{ld: (t == 0), data: (t == 0) ? 32'h1234ABCD : $urandom, blz: 1'b0,
                            exp_en: 1'b1, exp_which: 3'(dg), exp_code: c_abcd[8*dg +: 8],
                            exp_fd: (t > 0) && (t % FRAME == 0)};
            end
        end

        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.data_in  = '0;
        bus.blank_lz = 1'b0;

        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        $display("reset enable=%b which=%0d code=%h fd=%b", bus.enable, bus.which, bus.code, bus.frame_done);
        check("reset_enable", bus.enable, 0);
        check("reset_which", bus.which, 0);
        check("reset_code", bus.code, 8'hFF);
        check("reset_frame_done", bus.frame_done, 0);

        for (int i = 0; i < NV; i++) begin
            step(1'b0, vecs[i].ld, vecs[i].data, vecs[i].blz);
            $display("vec %0d load=%b which=%0d code=%h fd=%b", i, vecs[i].ld, bus.which, bus.code, bus.frame_done);
            check("vec_enable", bus.enable, vecs[i].exp_en);
            check("vec_which", bus.which, vecs[i].exp_which);
            check("vec_code", bus.code, vecs[i].exp_code);
            check("vec_frame_done", bus.frame_done, vecs[i].exp_fd);
        end
        tcur = 2 * FRAME;

        // Queue 0x11111111, then a mid-frame load at digit 3 must not disturb the frame.
        scan_steps(31, c_abcd, 1'b0, 0, 32'h11111111);
        scan_steps(32, all_f9, 1'b0, 13, 32'h22222222);
        // Two loads in one frame: the later one wins.
        scan_steps(10, all_a4, 1'b0, 2, 32'h33333333);
        scan_steps(22, all_a4, 1'b0, 5, 32'h44444444);
        // A pending value is overridden by a load on the boundary cycle itself.
        scan_steps(32, all_99, 1'b0, 7, 32'h55555555);
        scan_steps(32, all_88, 1'b0, 0, 32'hAAAAAAAA);
        scan_steps(32, all_88, 1'b0, -1, 32'h0);
        scan_steps(21, all_88, 1'b0, -1, 32'h0);

        // Reset while showing digit 5.
        check("pre_reset_which", bus.which, 5);
        step(1'b1, 1'b0, $urandom, 1'b0);
        $display("mid reset enable=%b which=%0d code=%h", bus.enable, bus.which, bus.code);
        check("midrst_enable", bus.enable, 0);
        check("midrst_which", bus.which, 0);
        check("midrst_code", bus.code, 8'hFF);
        check("midrst_frame_done", bus.frame_done, 0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, $urandom, 1'($urandom_range(0, 1)));
            check("post_rst_idle_enable", bus.enable, 0);
            check("post_rst_idle_code", bus.code, 8'hFF);
        end

        // Leading-zero blanking with 0x50, then without, then a zero loaded at the boundary.
        step(1'b0, 1'b1, 32'h00000050, 1'b1);
        tcur = 0;
        $display("reload which=%0d code=%h", bus.which, bus.code);
        check("reload_enable", bus.enable, 1);
        check("reload_which", bus.which, 0);
        check("reload_code", bus.code, 8'hC0);
        scan_steps(31, blank50, 1'b1, -1, 32'h0);
        scan_steps(32, plain50, 1'b0, -1, 32'h0);
        scan_steps(1, zero_blz, 1'b1, 0, 32'h0);
        scan_steps(31, zero_blz, 1'b1, -1, 32'h0);

        // Random traffic against the reference model.
        begin
            logic b;
            b = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                logic        r, l;
                logic [31:0] d;
                r = ($urandom_range(0, 299) == 0);
                l = ($urandom_range(0, 15) == 0);
                d = $urandom >> (4 * $urandom_range(0, 8));
                if ($urandom_range(0, 19) == 0) b = ~b;
                step(r, l, d, b);
                if (l || r) begin
                    $display("rand %0d rst=%b load=%b data=%h which=%0d code=%h", i, r, l, d, bus.which, bus.code);
                end
                check("rand_enable", bus.enable, m_started);
                check("rand_which", bus.which, model_which());
                check("rand_code", bus.code, model_code());
                check("rand_frame_done", bus.frame_done, model_fd());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
